// File: rtl/sdram_pkg.sv
// Shared SDRAM controller constants: command codes {cs_n, ras_n, cas_n, we_n},
// arbiter state encoding and the idle bank/address values for the default geometry.
package sdram_pkg;

  localparam logic [3:0] NOP   = 4'b0111;
  localparam logic [3:0] PRE   = 4'b0010;
  localparam logic [3:0] AREF  = 4'b0001;
  localparam logic [3:0] MREG  = 4'b0000;
  localparam logic [3:0] ACT   = 4'b0011;
  localparam logic [3:0] WR    = 4'b0100;
  localparam logic [3:0] RD    = 4'b0101;
  localparam logic [3:0] BSTOP = 4'b0110;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_ARBIT = 3'd1;
  localparam logic [2:0] ST_AREF  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  localparam logic [1:0]  IDLE_BA   = 2'b11;
  localparam logic [12:0] IDLE_ADDR = 13'h1FFF;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Selects the granted engine's cmd/ba/addr/dq onto the SDRAM pins.
// With SDRAM_CMD_REG_EN defined, all pin outputs pass through one register stage.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
) (
`ifdef SDRAM_CMD_REG_EN
  input  logic              clk_100m,
`endif
  input  logic              sys_rst_n,
  input  logic [2:0]        i_state,
  input  logic [3:0]        i_init_cmd,
  input  logic [BA_W-1:0]   i_init_ba,
  input  logic [ADDR_W-1:0] i_init_addr,
  input  logic [3:0]        i_aref_cmd,
  input  logic [BA_W-1:0]   i_aref_ba,
  input  logic [ADDR_W-1:0] i_aref_addr,
  input  logic [3:0]        i_wr_cmd,
  input  logic [BA_W-1:0]   i_wr_ba,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [3:0]        i_rd_cmd,
  input  logic [BA_W-1:0]   i_rd_ba,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_wr_sdram_en,
  input  logic [DQ_W-1:0]   i_wr_data,
  output logic [3:0]        o_cmd,
  output logic [BA_W-1:0]   o_ba,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DQ_W-1:0]   o_dq,
  output logic              o_dq_oe
);

  logic [3:0]        w_cmd;
  logic [BA_W-1:0]   w_ba;
  logic [ADDR_W-1:0] w_addr;
  logic              w_dq_oe;

  // Pin selection by state; reset forces NOP/idle so pins are quiet the instant reset asserts
  always_comb begin
    w_cmd   = NOP;
    w_ba    = {BA_W{1'b1}};
    w_addr  = {ADDR_W{1'b1}};
    w_dq_oe = 1'b0;
    if (!sys_rst_n) begin
      w_cmd = NOP;
    end else begin
      case (i_state)
        ST_INIT: begin
          w_cmd  = i_init_cmd;
          w_ba   = i_init_ba;
          w_addr = i_init_addr;
        end
        ST_AREF: begin
          w_cmd  = i_aref_cmd;
          w_ba   = i_aref_ba;
          w_addr = i_aref_addr;
        end
        ST_WRITE: begin
          w_cmd   = i_wr_cmd;
          w_ba    = i_wr_ba;
          w_addr  = i_wr_addr;
          w_dq_oe = i_wr_sdram_en;
        end
        ST_READ: begin
          w_cmd  = i_rd_cmd;
          w_ba   = i_rd_ba;
          w_addr = i_rd_addr;
        end
        default: w_cmd = NOP;
      endcase
    end
  end

`ifdef SDRAM_CMD_REG_EN
  logic [3:0]        r_cmd;
  logic [BA_W-1:0]   r_ba;
  logic [ADDR_W-1:0] r_addr;
  logic [DQ_W-1:0]   r_dq;
  logic              r_dq_oe;

  // Output register stage: one cycle of pin latency, resets to NOP/idle/high-Z
  always_ff @(posedge clk_100m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd   <= NOP;
      r_ba    <= {BA_W{1'b1}};
      r_addr  <= {ADDR_W{1'b1}};
      r_dq    <= {DQ_W{1'b0}};
      r_dq_oe <= 1'b0;
    end else begin
      r_cmd   <= w_cmd;
      r_ba    <= w_ba;
      r_addr  <= w_addr;
      r_dq    <= i_wr_data;
      r_dq_oe <= w_dq_oe;
    end
  end

  assign o_cmd   = r_cmd;
  assign o_ba    = r_ba;
  assign o_addr  = r_addr;
  assign o_dq    = r_dq;
  assign o_dq_oe = r_dq_oe;
`else
  assign o_cmd   = w_cmd;
  assign o_ba    = w_ba;
  assign o_addr  = w_addr;
  assign o_dq    = i_wr_data;
  assign o_dq_oe = w_dq_oe;
`endif

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM controller arbiter: fixed-priority grant (aref > write > read) after init,
// and the command/data pin mux. Optional macro SDRAM_CMD_REG_EN registers the pins.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
) (
  input  logic              clk_100m,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic            r_aref_en;
  logic            r_wr_en;
  logic            r_rd_en;
  logic            r_cke;
  logic [3:0]      w_cmd;
  logic [DQ_W-1:0] w_dq;
  logic            w_dq_oe;

  // Next-state: requests are only looked at in ARBIT; *_end outside its own state is ignored
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: begin
        if (init_end) w_next = ST_ARBIT;
        else          w_next = ST_INIT;
      end
      ST_ARBIT: begin
        if (aref_req)    w_next = ST_AREF;
        else if (wr_req) w_next = ST_WRITE;
        else if (rd_req) w_next = ST_READ;
        else             w_next = ST_ARBIT;
      end
      ST_AREF: begin
        if (aref_end) w_next = ST_ARBIT;
        else          w_next = ST_AREF;
      end
      ST_WRITE: begin
        if (wr_end) w_next = ST_ARBIT;
        else        w_next = ST_WRITE;
      end
      ST_READ: begin
        if (rd_end) w_next = ST_ARBIT;
        else        w_next = ST_READ;
      end
      default: w_next = ST_INIT;
    endcase
  end

  // State, grant and clock-enable registers; grants decode the next state so they track it exactly
  always_ff @(posedge clk_100m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_INIT;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_cke     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aref_en <= (w_next == ST_AREF);
      r_wr_en   <= (w_next == ST_WRITE);
      r_rd_en   <= (w_next == ST_READ);
      r_cke     <= 1'b1;
    end
  end

  sdram_cmd_mux #(
    .ADDR_W (ADDR_W),
    .BA_W   (BA_W),
    .DQ_W   (DQ_W)
  ) u_cmd_mux (
`ifdef SDRAM_CMD_REG_EN
    .clk_100m      (clk_100m),
`endif
    .sys_rst_n     (sys_rst_n),
    .i_state       (r_state),
    .i_init_cmd    (init_cmd),
    .i_init_ba     (init_ba),
    .i_init_addr   (init_addr),
    .i_aref_cmd    (aref_cmd),
    .i_aref_ba     (aref_ba),
    .i_aref_addr   (aref_addr),
    .i_wr_cmd      (wr_cmd),
    .i_wr_ba       (wr_ba),
    .i_wr_addr     (wr_addr),
    .i_rd_cmd      (rd_cmd),
    .i_rd_ba       (rd_ba),
    .i_rd_addr     (rd_addr),
    .i_wr_sdram_en (wr_sdram_en),
    .i_wr_data     (wr_data),
    .o_cmd         (w_cmd),
    .o_ba          (sdram_ba),
    .o_addr        (sdram_addr),
    .o_dq          (w_dq),
    .o_dq_oe       (w_dq_oe)
  );

  assign aref_en     = r_aref_en;
  assign wr_en       = r_wr_en;
  assign rd_en       = r_rd_en;
  assign sdram_cke   = r_cke;
  assign sdram_cs_n  = w_cmd[3];
  assign sdram_ras_n = w_cmd[2];
  assign sdram_cas_n = w_cmd[1];
  assign sdram_we_n  = w_cmd[0];
  assign sdram_dq    = w_dq_oe ? w_dq : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed, table-driven bench for sdram_arbit; expected pins come from a small
// bench-side model of which engine owns the bus (lagged one edge under SDRAM_CMD_REG_EN).
module tb_sdram_arbit;

  localparam logic [2:0] C_INIT = 3'd0;
  localparam logic [2:0] C_ARB  = 3'd1;
  localparam logic [2:0] C_AREF = 3'd2;
  localparam logic [2:0] C_WR   = 3'd3;
  localparam logic [2:0] C_RD   = 3'd4;
  localparam logic [2:0] C_RST  = 3'd7;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq;
  } pins_t;

  typedef struct packed {
    logic ie, ar, ae, wq, we, rq, re, sen;
    logic [2:0] ex;
  } vec_t;

  logic        clk_100m = 1'b0;
  logic        sys_rst_n;
  logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
  logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  wire  [15:0] sdram_dq;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [2:0]  cur_code;
  pins_t       reg_pins;
  logic        exp_cke;
  vec_t        vt [23];

  sdram_arbit dut (
    .clk_100m (clk_100m), .sys_rst_n (sys_rst_n), .init_end (init_end),
    .init_cmd (init_cmd), .init_ba (init_ba), .init_addr (init_addr),
    .aref_req (aref_req), .aref_end (aref_end),
    .aref_cmd (aref_cmd), .aref_ba (aref_ba), .aref_addr (aref_addr),
    .wr_req (wr_req), .wr_end (wr_end), .wr_cmd (wr_cmd), .wr_ba (wr_ba), .wr_addr (wr_addr),
    .wr_sdram_en (wr_sdram_en), .wr_data (wr_data),
    .rd_req (rd_req), .rd_end (rd_end), .rd_cmd (rd_cmd), .rd_ba (rd_ba), .rd_addr (rd_addr),
    .aref_en (aref_en), .wr_en (wr_en), .rd_en (rd_en), .sdram_cke (sdram_cke),
    .sdram_cs_n (sdram_cs_n), .sdram_ras_n (sdram_ras_n), .sdram_cas_n (sdram_cas_n),
    .sdram_we_n (sdram_we_n), .sdram_ba (sdram_ba), .sdram_addr (sdram_addr),
    .sdram_dq (sdram_dq)
  );

  always #5 clk_100m = ~clk_100m;

  function automatic pins_t model(input logic [2:0] code);
    pins_t p;
    p = {4'b0111, 2'b11, 13'h1FFF, 16'hzzzz};
    case (code)
      C_INIT: p = {init_cmd, init_ba, init_addr, 16'hzzzz};
      C_AREF: p = {aref_cmd, aref_ba, aref_addr, 16'hzzzz};
      C_WR:   p = {wr_cmd, wr_ba, wr_addr, (wr_sdram_en ? wr_data : 16'hzzzz)};
      C_RD:   p = {rd_cmd, rd_ba, rd_addr, 16'hzzzz};
      default: p = {4'b0111, 2'b11, 13'h1FFF, 16'hzzzz};
    endcase
    return p;
  endfunction

  function automatic vec_t mk(input logic [7:0] ins, input logic [2:0] ex);
    vec_t v;
    {v.ie, v.ar, v.ae, v.wq, v.we, v.rq, v.re, v.sen} = ins;
    v.ex = ex;
    return v;
  endfunction

  task automatic check(input string name);
    pins_t exp_p;
    pins_t got_p;
    logic [2:0] exp_en;
    logic [2:0] got_en;
`ifdef SDRAM_CMD_REG_EN
    exp_p = reg_pins;
`else
    exp_p = model(cur_code);
`endif
    exp_en = {cur_code == C_AREF, cur_code == C_WR, cur_code == C_RD};
    got_en = {aref_en, wr_en, rd_en};
    got_p  = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr, sdram_dq};
    n_vec++;
    if (got_p !== exp_p || got_en !== exp_en || sdram_cke !== exp_cke) begin
      n_bad++;
      $display("FAIL %s: got en(aref,wr,rd)=%b cke=%b cmd=%b ba=%b addr=%h dq=%h, want en=%b cke=%b cmd=%b ba=%b addr=%h dq=%h",
               name, got_en, sdram_cke, got_p.cmd, got_p.ba, got_p.addr, got_p.dq,
               exp_en, exp_cke, exp_p.cmd, exp_p.ba, exp_p.addr, exp_p.dq);
    end
  endtask

  // One clock edge; the registered-pin image captures the bus owner from before the edge
  task automatic step(input logic [2:0] next_code);
    reg_pins = model(cur_code);
    @(posedge clk_100m);
    #1;
    cur_code = next_code;
    exp_cke  = 1'b1;
  endtask

  initial begin
    //                 ie ar ae wq we rq re sen
    vt[0]  = mk(8'b0_0_0_0_0_0_0_0, C_INIT);
    vt[1]  = mk(8'b0_1_0_0_0_0_0_0, C_INIT);
    vt[2]  = mk(8'b1_1_0_0_0_0_0_0, C_ARB);
    vt[3]  = mk(8'b1_1_0_1_0_1_0_0, C_AREF);
    vt[4]  = mk(8'b1_1_0_1_1_1_1_0, C_AREF);
    vt[5]  = mk(8'b1_0_1_1_0_1_0_0, C_ARB);
    vt[6]  = mk(8'b1_0_0_1_0_1_0_0, C_WR);
    vt[7]  = mk(8'b1_0_0_0_0_1_0_1, C_WR);
    vt[8]  = mk(8'b1_0_0_0_0_1_0_0, C_WR);
    vt[9]  = mk(8'b1_0_1_0_1_1_0_1, C_ARB);
    vt[10] = mk(8'b1_0_0_0_0_1_0_0, C_RD);
    vt[11] = mk(8'b1_0_0_0_0_0_0_1, C_RD);
    vt[12] = mk(8'b1_0_0_0_0_1_1_0, C_ARB);
    vt[13] = mk(8'b1_0_0_0_0_1_0_0, C_RD);
    vt[14] = mk(8'b0_0_0_0_0_0_1_0, C_ARB);
    vt[15] = mk(8'b0_0_0_0_0_0_0_0, C_ARB);
    vt[16] = mk(8'b0_0_0_1_0_0_0_0, C_WR);
    vt[17] = mk(8'b0_1_0_0_1_0_0_0, C_ARB);
    vt[18] = mk(8'b0_1_0_0_0_0_0_0, C_AREF);
    vt[19] = mk(8'b0_1_1_0_0_0_0_0, C_ARB);
    vt[20] = mk(8'b0_0_0_0_0_0_0_0, C_ARB);
    vt[21] = mk(8'b0_0_0_1_0_0_0_0, C_WR);
    vt[22] = mk(8'b0_0_0_0_0_0_0_1, C_WR);

    sys_rst_n = 1'b0;
    {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en} = 8'b0;
    init_cmd  = 4'b0111; init_ba = 2'b11; init_addr = 13'h1FFF;
    aref_cmd  = 4'b0001; aref_ba = 2'b01; aref_addr = 13'h0AAA;
    wr_cmd    = 4'b0100; wr_ba   = 2'b10; wr_addr   = 13'h0123;
    rd_cmd    = 4'b0101; rd_ba   = 2'b00; rd_addr   = 13'h0456;
    wr_data   = 16'hA5A5;
    cur_code  = C_RST;
    reg_pins  = model(C_RST);
    exp_cke   = 1'b0;

    repeat (2) @(posedge clk_100m);
    #1;
    check("reset_held");
    sys_rst_n = 1'b1;
    cur_code  = C_INIT;
    #1;
    check("reset_release");
    step(C_INIT);
    check("init_idle_cke");
    init_cmd = 4'b0010; init_ba = 2'b00; init_addr = 13'h0400;
    #1;
    check("init_cmd_passthru");
    step(C_INIT);
    check("init_cmd_after_edge");

    for (int i = 0; i < 23; i++) begin
      {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en} =
        {vt[i].ie, vt[i].ar, vt[i].ae, vt[i].wq, vt[i].we, vt[i].rq, vt[i].re, vt[i].sen};
      step(vt[i].ex);
      check($sformatf("vec%0d", i));
    end

    // Reset pulled mid-WRITE while dq is being driven
    #2;
    sys_rst_n = 1'b0;
    #1;
    cur_code = C_RST;
    reg_pins = model(C_RST);
    exp_cke  = 1'b0;
    check("reset_mid_write");
    #1;
    sys_rst_n = 1'b1;
    {init_end, wr_req, wr_sdram_en} = 3'b010;
    cur_code = C_INIT;
    #1;
    check("post_reset_release");
    step(C_INIT);
    check("wait_init_end_1");
    step(C_INIT);
    check("wait_init_end_2");
    init_end = 1'b1;
    step(C_ARB);
    check("post_reset_arbit");
    step(C_WR);
    check("post_reset_write");
    {wr_req, wr_end} = 2'b01;
    step(C_ARB);
    check("post_reset_release_wr");
    wr_end = 1'b0;
    step(C_ARB);
    check("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
